led_status_driver: RTL

//  Parametrised multi-channel LED status driver, successor to the ad-hoc per-LED blink counters in Top.
//  One shared prescaler produces a tick. Each channel is set per lane to OFF, ON, BLINK (shared phase)
//  or ACTIVITY (event pulse stretched to a visible length), with per-channel PWM dimming.
//  It sits in the sys_clk domain and drives LED[] directly from registered outputs.

---
 rtl/led_status_driver.sv | 121 ++++++++++++
 1 files changed

// File: rtl/led_status_driver.sv
// Multi-channel LED status driver: shared prescaler tick and blink phase feed per-channel lanes
// that select OFF/ON/BLINK/ACTIVITY, stretch activity strobes (evt) and apply PWM dimming.

module led_status_lane #(
  parameter int STRETCH_TICKS = 50,
  parameter int PWM_BITS      = 4
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic                tick,
  input  logic                phase,
  input  logic                evt,
  input  logic [1:0]          mode,
  input  logic [PWM_BITS-1:0] bright,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  output logic                led
);
  localparam int SW = $clog2(STRETCH_TICKS + 1);

  logic [SW-1:0] stretch;
  logic          act, dim, base;

  // A strobe reloads (and retriggers) the stretch even on a tick cycle.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst)          stretch <= '0;
    else if (evt)         stretch <= SW'(STRETCH_TICKS);
    else if (tick && act) stretch <= stretch - SW'(1);
  end

  assign act = |stretch;
  assign dim = (&bright) | (pwm_cnt < bright);

  always_comb begin
    base = 1'b0;
    case (mode)
      2'b01:   base = 1'b1;
      2'b10:   base = phase;
      2'b11:   base = act;
      default: base = 1'b0;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) led <= 1'b0;
    else         led <= base & dim;
  end
endmodule

module led_status_driver #(
  parameter int NCH           = 8,
  parameter int TICK_DIV      = 100000,
  parameter int BLINK_TICKS   = 500,
  parameter int STRETCH_TICKS = 50,
  parameter int PWM_BITS      = 4
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst,
  input  logic [NCH-1:0][1:0]           mode,
  input  logic [NCH-1:0][PWM_BITS-1:0]  bright,
  input  logic [NCH-1:0]                evt,
  output logic                          tick,
  output logic [NCH-1:0]                led
);
  localparam int PW = $clog2(TICK_DIV);
  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  logic [PW-1:0]       pre_cnt;
  logic [BW-1:0]       blink_cnt;
  logic                phase;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                pre_wrap;

  assign pre_wrap = (pre_cnt == PW'(TICK_DIV - 1));

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      pre_cnt <= '0;
      tick    <= 1'b0;
    end else begin
      tick    <= pre_wrap;
      pre_cnt <= pre_wrap ? '0 : pre_cnt + PW'(1);
    end
  end

  // One phase bit shared by every BLINK channel keeps them coherent.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else if (tick) begin
      if (blink_cnt == BW'(BLINK_TICKS - 1)) begin
        blink_cnt <= '0;
        phase     <= ~phase;
      end else begin
        blink_cnt <= blink_cnt + BW'(1);
      end
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) pwm_cnt <= '0;
    else         pwm_cnt <= pwm_cnt + PWM_BITS'(1);
  end

  for (genvar i = 0; i < NCH; i++) begin : g_lane
    led_status_lane #(
      .STRETCH_TICKS (STRETCH_TICKS),
      .PWM_BITS      (PWM_BITS)
    ) u_lane (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .tick    (tick),
      .phase   (phase),
      .evt     (evt[i]),
      .mode    (mode[i]),
      .bright  (bright[i]),
      .pwm_cnt (pwm_cnt),
      .led     (led[i])
    );
  end
endmodule
